lc3b_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined LC-3b core. It sits directly upstream of the IF/ID register and decode logic.
- Owns the fetch PC and issues word reads to instruction memory over a read/resp handshake.
- Buffers returned instructions with their PCs in a small queue and presents the queue head to decode.
- Accepts redirects (branch, JMP, TRAP) from later stages and drops wrong-path responses that are still in flight.

---
 rtl/lc3b_types.sv | 25 ++
 rtl/lc3b_fetch_unit_if.sv | 29 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/lc3b_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_lc3b_fetch_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lc3b_types                                                    |
// | Brief    : Shared LC-3b word type plus fetch-stage state and entry types.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam lc3b_word LC3B_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    lc3b_word instr;
    lc3b_word pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/lc3b_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lc3b_fetch_unit_if                                            |
// | Brief    : Instruction-memory read/resp handshake bundle.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface lc3b_fetch_unit_if;

  lc3b_types::lc3b_word imem_addr;
  logic                 imem_read;
  lc3b_types::lc3b_word imem_rdata;
  logic                 imem_resp;

  modport master (
    output imem_addr,
    output imem_read,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_addr,
    input  imem_read,
    output imem_rdata,
    output imem_resp
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_queue                                                   |
// | Brief    : DEPTH-entry FIFO of fetched {instr, pc} with flush.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fetch_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  fetch_entry_t         r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_head;
  logic [c_ptr_w-1:0]   r_tail;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_head];
  // A push into a full queue is accepted only when the head leaves the same cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= f_next(r_tail);
      end
      if (w_do_pop) begin
        r_head <= f_next(r_head);
      end
      r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lc3b_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lc3b_fetch_unit                                               |
// | Brief    : LC-3b fetch stage: PC, imem handshake, redirect, instr queue. |
// |            Define FETCH_BYPASS_EN to forward responses to decode when    |
// |            the queue is empty.                                           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module lc3b_fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = LC3B_RESET_PC,
  parameter int       QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  lc3b_fetch_unit_if.master  imem,
  input  logic               redirect,
  input  lc3b_word           redirect_pc,
  input  logic               advance,
  output lc3b_word           instr,
  output lc3b_word           instr_pc,
  output logic               instr_valid
);

  localparam int       c_cnt_w    = $clog2(QDEPTH + 1);
  localparam lc3b_word c_pc_mask  = 16'hFFFE;
  localparam lc3b_word c_reset_pc = RESET_PC & c_pc_mask;

  fetch_state_t        r_state;
  lc3b_word            r_fetch_pc;
  lc3b_word            r_imem_addr;
  logic                r_imem_read;

  fetch_entry_t        w_q_head;
  logic                w_q_full;
  logic                w_q_empty;
  logic [c_cnt_w-1:0]  w_q_count;
  lc3b_word            w_redirect_pc;
  logic                w_resp_ok;
  logic                w_push;
  logic                w_pop;
  logic                w_space;
  logic                w_space_after;

  assign imem.imem_addr = r_imem_addr;
  assign imem.imem_read = r_imem_read;

  assign w_redirect_pc = redirect_pc & c_pc_mask;
  assign w_resp_ok     = (r_state == REQ) & imem.imem_resp & ~redirect;
  assign w_pop         = advance & ~w_q_empty & ~redirect;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_q_empty & w_resp_ok;
  // A forwarded word that decode takes immediately never enters the queue.
  assign w_push      = w_resp_ok & ~(w_bypass & advance);
  assign instr       = w_bypass ? imem.imem_rdata : w_q_head.instr;
  assign instr_pc    = w_bypass ? r_imem_addr     : w_q_head.pc;
  assign instr_valid = ~w_q_empty | w_bypass;
`else
  assign w_push      = w_resp_ok;
  assign instr       = w_q_head.instr;
  assign instr_pc    = w_q_head.pc;
  assign instr_valid = ~w_q_empty;
`endif

  assign w_space       = ~w_q_full | w_pop;
  assign w_space_after = (4'(w_q_count) + 4'(w_push) - 4'(w_pop)) < 4'(QDEPTH);

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data ({imem.imem_rdata, r_imem_addr}),
    .pop       (w_pop),
    .flush     (redirect),
    .head      (w_q_head),
    .full      (w_q_full),
    .empty     (w_q_empty),
    .count     (w_q_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_fetch_pc  <= c_reset_pc;
      r_imem_addr <= c_reset_pc;
      r_imem_read <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
          end else if (w_space) begin
            r_state     <= REQ;
            r_imem_addr <= r_fetch_pc;
            r_imem_read <= 1'b1;
          end
        end
        REQ: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            // Memory cannot abort a read: keep the request up and drain it in DROP.
            if (imem.imem_resp) begin
              r_state     <= IDLE;
              r_imem_read <= 1'b0;
            end else begin
              r_state <= DROP;
            end
          end else if (imem.imem_resp) begin
            r_fetch_pc <= r_imem_addr + 16'd2;
            if (w_space_after) begin
              r_imem_addr <= r_imem_addr + 16'd2;
            end else begin
              r_state     <= IDLE;
              r_imem_read <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
          end
          if (imem.imem_resp) begin
            r_state     <= IDLE;
            r_imem_read <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_imem_read <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc3b_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lc3b_fetch_unit                                            |
// | Brief    : Directed scoreboard bench for lc3b_fetch_unit (QDEPTH=2).     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_lc3b_fetch_unit;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         redirect;
  lc3b_word     redirect_pc;
  logic         advance;
  lc3b_word     instr;
  lc3b_word     instr_pc;
  logic         instr_valid;

  int           n_cmp = 0;
  int           n_err = 0;
  int           mem_lat = 1;
  lc3b_word     req_log[$];
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  lc3b_fetch_unit_if bus();

  lc3b_fetch_unit #(
    .RESET_PC (16'h0000),
    .QDEPTH   (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (advance),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  // Memory: answers each read mem_lat falling edges after it is seen, data = addr ^ A5A5.
  initial begin
    int cnt;
    cnt = 0;
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.imem_resp = 1'b0;
        cnt = 0;
      end else begin
        if (bus.imem_resp) begin
          bus.imem_resp = 1'b0;
          cnt = 0;
        end
        if (bus.imem_read) begin
          cnt++;
          if (cnt >= mem_lat) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;
            req_log.push_back(bus.imem_addr);
          end
        end
      end
    end
  end

  function automatic fetch_entry_t mk(input lc3b_word pc);
    fetch_entry_t e;
    e.instr = pc ^ 16'hA5A5;
    e.pc    = pc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, " valid"}, 16'(instr_valid), 16'd1);
  endtask

  task automatic wait_read(input string tag, input lc3b_word addr);
    int n = 0;
    while (!bus.imem_read && n < 30) begin
      step();
      n++;
    end
    chk({tag, " read"}, 16'(bus.imem_read), 16'd1);
    chk({tag, " addr"}, bus.imem_addr, addr);
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (!bus.imem_resp && n < 30) begin
      step();
      n++;
    end
    chk({tag, " resp"}, 16'(bus.imem_resp), 16'd1);
  endtask

  task automatic consume(input string tag);
    fetch_entry_t e;
    wait_valid(tag);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed output with empty scoreboard, expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " pc"}, instr_pc, e.pc);
      chk({tag, " instr"}, instr, e.instr);
    end
    advance = 1'b1;
    step();
    advance = 1'b0;
  endtask

  initial begin
    logic seen_valid;
    logic found;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    advance     = 1'b0;
    repeat (2) step();

    chk("rst read", 16'(bus.imem_read), 16'd0);
    chk("rst addr", bus.imem_addr, 16'h0000);
    chk("rst valid", 16'(instr_valid), 16'd0);
    chk("rst instr", instr, 16'h0000);
    chk("rst pc", instr_pc, 16'h0000);

    reset_n = 1'b1;
    wait_read("first", 16'h0000);

    // Stall decode: two responses fill the queue and fetch stops.
    repeat (5) step();
    chk("full read", 16'(bus.imem_read), 16'd0);
    chk("full nreq", 16'(req_log.size()), 16'd2);
    chk("full req1", req_log[1], 16'h0002);
    chk("full head pc", instr_pc, 16'h0000);
    sb.push_back(mk(16'h0000));
    consume("pop0");

    repeat (5) step();
    chk("one more nreq", 16'(req_log.size()), 16'd3);
    chk("one more req2", req_log[2], 16'h0004);
    chk("one more read", 16'(bus.imem_read), 16'd0);

    // Redirect while 0x0006 is outstanding.
    mem_lat = 3;
    sb.push_back(mk(16'h0002));
    consume("pop2");
    chk("out read", 16'(bus.imem_read), 16'd1);
    chk("out addr", bus.imem_addr, 16'h0006);
    redirect    = 1'b1;
    redirect_pc = 16'h3001;
    step();
    redirect = 1'b0;
    mem_lat  = 1;
    chk("drop valid", 16'(instr_valid), 16'd0);
    chk("drop read", 16'(bus.imem_read), 16'd1);
    chk("drop addr", bus.imem_addr, 16'h0006);
    seen_valid = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      step();
      if (instr_valid) seen_valid = 1'b1;
      if (bus.imem_read && bus.imem_addr == 16'h3000) found = 1'b1;
    end
    chk("drop no valid", 16'(seen_valid), 16'd0);
    chk("redir addr 3000", 16'(found), 16'd1);
    sb.push_back(mk(16'h3000));
    consume("pc3000");

    // Redirect, response and advance all in one cycle.
    wait_resp("triple");
    chk("triple head valid", 16'(instr_valid), 16'd1);
    chk("triple head pc", instr_pc, 16'h3002);
    redirect    = 1'b1;
    redirect_pc = 16'h4000;
    advance     = 1'b1;
    step();
    redirect = 1'b0;
    advance  = 1'b0;
    chk("triple valid", 16'(instr_valid), 16'd0);
    chk("triple read", 16'(bus.imem_read), 16'd0);
    wait_read("triple next", 16'h4000);
    sb.push_back(mk(16'h4000));
    consume("pc4000");

    // Wrap-around of the fetch PC.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    sb.push_back(mk(16'hFFFE));
    sb.push_back(mk(16'h0000));
    consume("wrap fffe");
    consume("wrap 0000");

    // Asynchronous reset in the middle of a request.
    repeat (6) step();
    chk("pre rst valid", 16'(instr_valid), 16'd1);
    chk("pre rst pc", instr_pc, 16'h0002);
    mem_lat = 4;
    sb.push_back(mk(16'h0002));
    consume("pre rst pop");
    chk("mid req read", 16'(bus.imem_read), 16'd1);
    chk("mid req addr", bus.imem_addr, 16'h0006);
    reset_n = 1'b0;
    #1;
    chk("async read", 16'(bus.imem_read), 16'd0);
    chk("async valid", 16'(instr_valid), 16'd0);
    chk("async addr", bus.imem_addr, 16'h0000);
    chk("async pc", instr_pc, 16'h0000);
    step();
    reset_n = 1'b1;
    mem_lat = 1;
    wait_read("post rst", 16'h0000);
    sb.push_back(mk(16'h0000));
    consume("post rst pc0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
